rr_grant_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among `NUM_REQ` agents with a bounded grant tenure. It is the fair-share successor to the fixed-priority four-agent grant FSM and sits between the agent request lines and the shared resource's select/enable. Grants are registered and one-hot. A hold counter forcibly revokes any grant that exceeds `MAX_HOLD` cycles, so no agent can starve the others.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 37 +++
 rtl/rr_grant_arbiter.sv | 117 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin grant arbiter.
// Holds the FSM encoding, parameter defaults and the hold-counter width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MAX_HOLD = 16;

    function automatic int hold_cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select: rotate req by ptr, priority-encode
// the lowest set bit, then add ptr back modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] dbl_shift;
    logic [NUM_REQ-1:0]   rot;
    logic [IW-1:0]        off;
    logic [IW:0]          sum;

    always_comb begin
        dbl_shift = {req, req} >> ptr;
        rot       = dbl_shift[NUM_REQ-1:0];
        off       = '0;
        // Scan downward so the lowest set bit (closest to ptr) wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
            end
        end
        valid = |req;
        sum   = {1'b0, off} + {1'b0, ptr};
        if (sum >= (IW+1)'(NUM_REQ)) begin
            idx = IW'(sum - (IW+1)'(NUM_REQ));
        end else begin
            idx = sum[IW-1:0];
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant and a bounded tenure;
// a holder exceeding MAX_HOLD cycles is revoked with a one-cycle timeout pulse.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       timeout,
    output logic [1:0]                 dbg_state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = hold_cnt_width(MAX_HOLD);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      id_q, id_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               to_q, to_d;

    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic [IW-1:0]      next_ptr;
    logic [HW-1:0]      hold_inc;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        next_ptr = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        hold_inc = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;

        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        to_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (pick_valid) begin
                    gnt_d[pick_idx] = 1'b1;
                    id_d            = pick_idx;
                    busy_d          = 1'b1;
                    hold_d          = '0;
                    state_d         = ST_GRANT;
                end
            end
            ST_GRANT: begin
                hold_d = hold_inc;
                // A voluntary release wins over a revoke on the same edge.
                if (!req[id_q]) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = next_ptr;
                    state_d = ST_RELEASE;
                end else if (hold_inc == HW'(MAX_HOLD)) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    to_d    = 1'b1;
                    ptr_d   = next_ptr;
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign busy      = busy_q;
    assign timeout   = to_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed plus randomized check of rr_grant_arbiter against a tenure-based
// reference model (owner, cycles held, rotating pointer).
module tb_rr_grant_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic         clock;
    logic         reset_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;
    logic [1:0]   dbg_state;

    int tests;
    int fails;

    int m_owner;
    int m_last;
    int m_ptr;
    int m_tenure;
    bit m_to;

    rr_grant_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 0;
        m_ptr    = 0;
        m_tenure = 0;
        m_to     = 0;
    endtask

    task automatic model_arbitrate(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (r[i] && m_owner < 0) begin
                m_owner  = i;
                m_last   = i;
                m_tenure = 1;
            end
        end
    endtask

    // m_tenure = number of cycles the current grant has already been visible.
    task automatic model_edge(input logic [N-1:0] r);
        m_to = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_tenure == MH) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_to    = 1;
            end else begin
                m_tenure++;
            end
        end else begin
            model_arbitrate(r);
        end
    endtask

    task automatic check(input string tag);
        logic [N-1:0] exp_gnt;
        logic [1:0]   exp_id;
        logic         exp_busy;
        logic         exp_to;
        exp_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        exp_id   = 2'(m_last);
        exp_busy = (m_owner >= 0);
        exp_to   = m_to;
        tests++;
        assert (gnt === exp_gnt) else begin
            fails++;
            $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, exp_gnt);
        end
        tests++;
        assert (gnt_id === exp_id) else begin
            fails++;
            $error("FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, exp_id);
        end
        tests++;
        assert (busy === exp_busy) else begin
            fails++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy, exp_busy);
        end
        tests++;
        assert (timeout === exp_to) else begin
            fails++;
            $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, exp_to);
        end
        tests++;
        assert ($onehot0(gnt)) else begin
            fails++;
            $error("FAIL %s onehot observed=%b expected=at_most_one_bit", tag, gnt);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input string tag);
        req = r;
        @(posedge clock);
        model_edge(r);
        #1;
        check(tag);
    endtask

    initial begin
        logic [N-1:0] r;
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        req     = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset");
        tests++;
        assert (dbg_state === 2'd0) else begin
            fails++;
            $error("FAIL reset_state observed=%0d expected=0", dbg_state);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // All four requesting: order 0,1,2,3,0 with revoke after MH cycles.
        for (int c = 0; c < 24; c++) step(4'b1111, "all_req");
        for (int c = 0; c < 3; c++) step(4'b0000, "drain1");

        // Lone requester repeatedly revoked and re-granted.
        for (int c = 0; c < 12; c++) step(4'b0001, "lone_req");
        for (int c = 0; c < 3; c++) step(4'b0000, "drain2");

        // Holder 1 drops early while 3 and 0 wait.
        step(4'b0010, "h1_grant");
        step(4'b1011, "h1_hold");
        step(4'b1001, "h1_drop");
        for (int c = 0; c < 4; c++) step(4'b1001, "after_h1");
        for (int c = 0; c < 3; c++) step(4'b0000, "drain3");

        // Drop exactly on the hold-limit edge.
        for (int c = 0; c < MH; c++) step(4'b0100, "limit_hold");
        step(4'b0000, "limit_drop");
        step(4'b1111, "limit_next");
        for (int c = 0; c < 3; c++) step(4'b0000, "drain4");

        // Single-cycle request pulse from idle.
        step(4'b1000, "pulse_on");
        step(4'b0000, "pulse_off");
        step(4'b0000, "pulse_idle");

        // Asynchronous reset in the middle of a grant.
        step(4'b0100, "pre_rst");
        step(4'b0100, "pre_rst_hold");
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        step(4'b1000, "post_rst");
        step(4'b1000, "post_rst_hold");
        for (int c = 0; c < 3; c++) step(4'b0000, "drain5");

        // Random level-held requests.
        r = '0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            step(r, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
